// File: rtl/apb_protocol_checker.sv
// Passive APB3 protocol checker: follows the IDLE/SETUP/ACCESS phases of one bus and
// reports handshake, stability, timeout and pslverr decode violations.
module apb_protocol_checker #(
    parameter int unsigned            ADDR_W     = 32,
    parameter int unsigned            DATA_W     = 32,
    parameter logic [ADDR_W-1:0]      BASE_ADDR  = '0,
    parameter int unsigned            NUM_REGS   = 3,
    parameter int unsigned            REG_STRIDE = 4,
    parameter int unsigned            TIMEOUT    = 16,
    parameter int unsigned            CNT_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pwrite,
    input  logic              psel,
    input  logic              penable,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr,
    output logic              err_valid,
    output logic [2:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [6:0]        err_sticky,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned       TW          = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W:0]   SPAN        = (ADDR_W+1)'(NUM_REGS * REG_STRIDE);
    localparam logic [ADDR_W-1:0] STRIDE_MASK = ADDR_W'(REG_STRIDE - 1);

    state_t              state, state_nx;
    logic [TW-1:0]       tcnt, tcnt_nx;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic                cap_write;
    logic                capture;
    logic                complete;
    logic                in_map;
    logic [ADDR_W-1:0]   offset;
    logic [7:1]          viol;
    logic [2:0]          code_nx;
    logic                unused_prdata;

    assign unused_prdata = ^prdata;
    assign busy          = (state != IDLE);

    // Decode is done on the address latched at SETUP, which stays put even if the bus wanders.
    assign offset = cap_addr - BASE_ADDR;
    assign in_map = (cap_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN) &&
                    ((offset & STRIDE_MASK) == '0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nx = state;
        tcnt_nx  = tcnt;
        capture  = 1'b0;
        complete = 1'b0;
        viol     = '0;
        unique case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nx = SETUP;
                    capture  = 1'b1;
                    tcnt_nx  = '0;
                end else if (psel && penable) begin
                    viol[1] = 1'b1;
                end
            end
            default: begin
                if (!psel) begin
                    viol[6]  = 1'b1;
                    state_nx = IDLE;
                    tcnt_nx  = '0;
                end else if (!penable) begin
                    viol[7]  = 1'b1;
                    capture  = 1'b1;
                    state_nx = SETUP;
                    tcnt_nx  = '0;
                end else begin
                    if (paddr != cap_addr || pwrite != cap_write || pwdata != cap_wdata)
                        viol[2] = 1'b1;
                    if (pready) begin
                        complete = 1'b1;
                        state_nx = IDLE;
                        tcnt_nx  = '0;
                        if (!in_map && !pslverr) viol[4] = 1'b1;
                        if (in_map && pslverr)   viol[5] = 1'b1;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        viol[3]  = 1'b1;
                        state_nx = IDLE;
                        tcnt_nx  = '0;
                    end else begin
                        state_nx = ACCESS;
                        tcnt_nx  = tcnt + 1'b1;
                    end
                end
            end
        endcase

        code_nx = '0;
        for (int i = 1; i <= 7; i++) begin
            if (viol[i] && code_nx == '0) code_nx = 3'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            tcnt       <= '0;
            // NOTE: capture registers are reset too, so a stale address can never be decoded.
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_write  <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_addr   <= '0;
            err_sticky <= '0;
            xfer_count <= '0;
            err_count  <= '0;
        end else begin
            state     <= state_nx;
            tcnt      <= tcnt_nx;
            if (capture) begin
                cap_addr  <= paddr;
                cap_wdata <= pwdata;
                cap_write <= pwrite;
            end
            err_valid <= |viol;
            err_code  <= code_nx;
            if (|viol) err_addr <= viol[1] ? paddr : cap_addr;
            if (clr) begin
                err_sticky <= '0;
                xfer_count <= '0;
                err_count  <= '0;
            end else begin
                err_sticky <= err_sticky | viol;
                if (complete && !(&xfer_count)) xfer_count <= xfer_count + 1'b1;
                if (|viol && !(&err_count))     err_count  <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Self-checking bench for apb_protocol_checker: directed table, hand-written corner
// sequences and randomized transfers scored against a transaction-level model.
module tb_apb_protocol_checker;

    localparam int          ADDR_W     = 32;
    localparam int          DATA_W     = 32;
    localparam logic [31:0] BASE       = 32'h0;
    localparam int          NUM_REGS   = 3;
    localparam int          REG_STRIDE = 4;
    localparam int          TIMEOUT    = 16;
    localparam int          CNT_W      = 8;

    logic              pclk, presetn;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata, prdata;
    logic              pwrite, psel, penable, pready, pslverr, clr;
    logic              err_valid;
    logic [2:0]        err_code;
    logic [ADDR_W-1:0] err_addr;
    logic [6:0]        err_sticky;
    logic [CNT_W-1:0]  xfer_count, err_count;
    logic              busy;

    apb_protocol_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE), .NUM_REGS(NUM_REGS),
        .REG_STRIDE(REG_STRIDE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pwrite(pwrite), .psel(psel), .penable(penable), .pready(pready), .pslverr(pslverr),
        .clr(clr), .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
        .err_sticky(err_sticky), .xfer_count(xfer_count), .err_count(err_count), .busy(busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        int          waits;
        bit          serr;
        int          exp_code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Inputs change on the falling edge; outputs are read on the falling edge after sampling.
    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // One transfer: SETUP, then waits cycles with pready low, then completion.
    // A transfer with waits >= TIMEOUT is abandoned after TIMEOUT low-ready cycles.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [31:0] wd,
                        input int waits, input bit serr,
                        output int pulses, output int code, output logic [31:0] eaddr);
        int n;
        pulses = 0; code = 0; eaddr = '0;
        paddr = a; pwrite = wr; pwdata = wd;
        psel = 1'b1; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
        tick();
        if (err_valid) pulses++;
        n = (waits >= TIMEOUT) ? TIMEOUT : waits + 1;
        for (int i = 0; i < n; i++) begin
            penable = 1'b1;
            pready  = (i == waits);
            pslverr = (i == waits) ? serr : 1'b0;
            tick();
            if (err_valid) begin
                pulses++;
                code  = int'(err_code);
                eaddr = err_addr;
            end
        end
        bus_idle();
    endtask

    function automatic bit in_map(input logic [31:0] a);
        longint off;
        if (a < BASE) return 1'b0;
        off = longint'(a) - longint'(BASE);
        return (off < NUM_REGS * REG_STRIDE) && (off % REG_STRIDE == 0);
    endfunction

    function automatic int model_code(input logic [31:0] a, input int waits, input bit serr);
        if (waits >= TIMEOUT)     return 3;
        if (!in_map(a) && !serr)  return 4;
        if (in_map(a) && serr)    return 5;
        return 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    int          p, c;
    logic [31:0] ea;
    int          ex_x, ex_e;
    logic [6:0]  ex_s;

    initial begin
        presetn = 1'b0; clr = 1'b0; paddr = '0; pwdata = '0; prdata = '0; pwrite = 1'b0;
        bus_idle();
        repeat (2) @(negedge pclk);

        check("reset_err_valid", 32'(err_valid), 0);
        check("reset_err_code", 32'(err_code), 0);
        check("reset_err_addr", err_addr, 0);
        check("reset_sticky", 32'(err_sticky), 0);
        check("reset_xfer_count", 32'(xfer_count), 0);
        check("reset_err_count", 32'(err_count), 0);
        check("reset_busy", 32'(busy), 0);
        presetn = 1'b1;
        tick();

        // Legal write to 0x4, ready on first access cycle.
        paddr = 32'h4; pwrite = 1'b1; pwdata = 32'hA5A5_0001; psel = 1'b1; penable = 1'b0;
        tick();
        check("legal_busy_setup", 32'(busy), 1);
        check("legal_noerr_setup", 32'(err_valid), 0);
        penable = 1'b1; pready = 1'b1;
        tick();
        check("legal_busy_done", 32'(busy), 0);
        check("legal_noerr_done", 32'(err_valid), 0);
        check("legal_xfer_count", 32'(xfer_count), 1);
        bus_idle();
        tick();

        // Out-of-map read at 0xC.
        xfer(32'hC, 1'b0, 32'h0, 0, 1'b0, p, c, ea);
        check("oom_pulses", 32'(p), 1);
        check("oom_code", 32'(c), 4);
        check("oom_addr", ea, 32'hC);
        check("oom_sticky", 32'(err_sticky), 32'b0001000);
        check("oom_err_count", 32'(err_count), 1);

        // Timeout on 0x8 after TIMEOUT low-ready cycles.
        xfer(32'h8, 1'b0, 32'h0, TIMEOUT, 1'b0, p, c, ea);
        check("tmo_pulses", 32'(p), 1);
        check("tmo_code", 32'(c), 3);
        check("tmo_addr", ea, 32'h8);
        check("tmo_busy", 32'(busy), 0);
        check("tmo_xfer_count", 32'(xfer_count), 2);

        // Address changes during the 2nd wait cycle, then completes with pslverr on 0x0.
        paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h1111; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1; pready = 1'b0;
        tick();
        check("chg_wait1_quiet", 32'(err_valid), 0);
        paddr = 32'h4;
        tick();
        check("chg_valid", 32'(err_valid), 1);
        check("chg_code", 32'(err_code), 2);
        check("chg_addr", err_addr, 32'h0);
        paddr = 32'h0; pready = 1'b1; pslverr = 1'b1;
        tick();
        check("spur_code", 32'(err_code), 5);
        check("spur_addr", err_addr, 32'h0);
        bus_idle();
        tick();
        check("chg_idle_quiet", 32'(err_valid), 0);

        // Enable without setup, then psel dropped mid-access.
        do_clr();
        check("clr_sticky", 32'(err_sticky), 0);
        check("clr_xfer", 32'(xfer_count), 0);
        paddr = 32'h1234; psel = 1'b1; penable = 1'b1;
        tick();
        check("ews_code", 32'(err_code), 1);
        check("ews_addr", err_addr, 32'h1234);
        bus_idle();
        tick();
        paddr = 32'h8; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        bus_idle();
        tick();
        check("drop_code", 32'(err_code), 6);
        check("drop_addr", err_addr, 32'h8);
        check("drop_sticky", 32'(err_sticky), 32'b0100001);
        check("drop_err_count", 32'(err_count), 2);
        check("drop_busy", 32'(busy), 0);

        // Setup repeated mid-access recaptures: completion decodes the new address 0x4.
        paddr = 32'h0; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        paddr = 32'h4; penable = 1'b0;
        tick();
        check("rep_code", 32'(err_code), 7);
        penable = 1'b1; pready = 1'b1; pslverr = 1'b1;
        tick();
        check("rep_cmpl_code", 32'(err_code), 5);
        check("rep_cmpl_addr", err_addr, 32'h4);
        check("rep_xfer", 32'(xfer_count), 1);
        bus_idle();
        tick();

        // Two violations in one cycle: signal change plus missing pslverr on 0xC.
        do_clr();
        paddr = 32'hC; psel = 1'b1; penable = 1'b0;
        tick();
        paddr = 32'h0; penable = 1'b1; pready = 1'b1;
        tick();
        check("multi_code", 32'(err_code), 2);
        check("multi_addr", err_addr, 32'hC);
        bus_idle();
        tick();
        check("multi_sticky", 32'(err_sticky), 32'b0001010);
        check("multi_err_count", 32'(err_count), 1);
        check("multi_xfer", 32'(xfer_count), 1);

        // Directed table.
        vecs.push_back('{32'h4,        1'b1, 0,  1'b0, 0});
        vecs.push_back('{32'hC,        1'b0, 0,  1'b0, 4});
        vecs.push_back('{32'h8,        1'b0, 16, 1'b0, 3});
        vecs.push_back('{32'h0,        1'b1, 2,  1'b1, 5});
        vecs.push_back('{32'h2,        1'b0, 0,  1'b0, 4});
        vecs.push_back('{32'h2,        1'b1, 1,  1'b1, 0});
        vecs.push_back('{32'h8,        1'b1, 15, 1'b0, 0});
        vecs.push_back('{32'h10,       1'b0, 3,  1'b1, 0});
        vecs.push_back('{32'hFFFF_FFFC, 1'b0, 0, 1'b0, 4});
        vecs.push_back('{32'h8,        1'b1, 20, 1'b1, 3});
        do_clr();
        ex_x = 0;
        foreach (vecs[k]) begin
            xfer(vecs[k].addr, vecs[k].wr, 32'hC0DE_0000 + 32'(k), vecs[k].waits, vecs[k].serr, p, c, ea);
            if (vecs[k].waits < TIMEOUT) ex_x++;
            check($sformatf("tbl%0d_pulses", k), 32'(p), (vecs[k].exp_code != 0) ? 1 : 0);
            check($sformatf("tbl%0d_code", k), 32'(c), 32'(vecs[k].exp_code));
            if (vecs[k].exp_code != 0) check($sformatf("tbl%0d_addr", k), ea, vecs[k].addr);
            check($sformatf("tbl%0d_xfer", k), 32'(xfer_count), 32'(ex_x));
        end

        // Randomized transfers against the transaction-level model.
        do_clr();
        ex_x = 0; ex_e = 0; ex_s = '0;
        for (int t = 0; t < 120; t++) begin
            logic [31:0] a;
            int          w, ec;
            bit          s;
            case ($urandom_range(0, 7))
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                3: a = 32'hC;
                4: a = 32'h2;
                5: a = 32'h6;
                6: a = 32'h10;
                default: a = $urandom;
            endcase
            w  = ($urandom_range(0, 9) == 0) ? 14 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            s  = 1'($urandom_range(0, 1));
            ec = model_code(a, w, s);
            xfer(a, 1'($urandom_range(0, 1)), $urandom, w, s, p, c, ea);
            check("rand_pulses", 32'(p), (ec != 0) ? 1 : 0);
            check("rand_code", 32'(c), 32'(ec));
            if (ec != 0) begin
                check("rand_addr", ea, a);
                ex_e = sat_inc(ex_e);
                ex_s[ec-1] = 1'b1;
            end
            if (w < TIMEOUT) ex_x = sat_inc(ex_x);
            repeat ($urandom_range(0, 2)) tick();
        end
        check("rand_xfer_count", 32'(xfer_count), 32'(ex_x));
        check("rand_err_count", 32'(err_count), 32'(ex_e));
        check("rand_sticky", 32'(err_sticky), 32'(ex_s));

        // Counter saturation, then clear coinciding with an erroneous completion.
        for (int t = 0; t < 300; t++) xfer(32'hC, 1'b0, 32'h0, 0, 1'b0, p, c, ea);
        check("sat_err_count", 32'(err_count), 255);
        check("sat_xfer_count", 32'(xfer_count), 255);
        paddr = 32'hC; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1; pready = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_pulse_still", 32'(err_valid), 1);
        check("clr_err_count", 32'(err_count), 0);
        check("clr_xfer_count", 32'(xfer_count), 0);
        check("clr_sticky_zero", 32'(err_sticky), 0);
        bus_idle();
        tick();

        // Asynchronous reset in the middle of an access.
        paddr = 32'h4; psel = 1'b1; penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        check("rst_busy_before", 32'(busy), 1);
        #2 presetn = 1'b0;
        #1 check("rst_busy_async", 32'(busy), 0);
        @(negedge pclk);
        bus_idle();
        presetn = 1'b1;
        tick();
        check("rst_no_error", 32'(err_valid), 0);
        check("rst_busy_after", 32'(busy), 0);
        check("rst_err_count", 32'(err_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
